// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive demo.
// The framing check is enabled by defining UART_RX_FRAME_CHECK_EN.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF input synchroniser, bit-timing counter, LSB-first shift register.
// Defining UART_RX_FRAME_CHECK_EN suppresses delivery of frames whose stop bit reads 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE = 11520,
  parameter int CLK_HZ   = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      rxd_i,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid
);

  localparam int CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF_BIT = CPB / 2;
  localparam int CW       = $clog2(CPB);
  localparam int BW       = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CNT_MID  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLK_HZ / BIT_RATE must be at least 4");
  end

  logic [1:0]                sync_q;
  uart_rx_state_t            state_q;
  logic [CW-1:0]             cnt_q;
  logic [BW-1:0]             bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      rxd_s;

  assign rxd_s   = sync_q[1];
  assign rx_data = shift_q;

  // The counter free-runs and is cleared at each phase boundary; IDLE is
  // re-entered at mid-stop-bit so a back-to-back start edge is not missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rxd_i};
      rx_valid <= 1'b0;
      cnt_q    <= cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (!rxd_s && en_i) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            if (rxd_s) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[UART_DATA_BITS-1:1]};
            bit_q   <= bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
            rx_valid <= rxd_s;
`else
            rx_valid <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_top.sv
// UART demo top: switch decode, last-byte display register and LED nibble mux.
// UART_RX_FRAME_CHECK_EN (see uart_rx) drops frames with a bad stop bit.
module uart_top
  import uart_pkg::*;
#(
  parameter int BIT_RATE = 11520,
  parameter int CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic [3:0] sw_0,
  input  logic       uart_rxd,
  output logic [3:0] led
);

  logic                      rst_n;
  logic                      rx_en;
  logic                      nib_sel;
  logic                      unused_sw;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic [UART_DATA_BITS-1:0] byte_d;

  assign rst_n     = sw_0[0];
  assign rx_en     = sw_0[1];
  assign nib_sel   = sw_0[2];
  assign unused_sw = sw_0[3];

  uart_rx #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (rx_en),
    .rxd_i   (uart_rxd),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  always_comb begin
    byte_d = byte_q;
    if (rx_valid) byte_d = rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byte_q <= '0;
    else        byte_q <= byte_d;
  end

  assign led = nib_sel ? byte_q[7:4] : byte_q[3:0];

endmodule

// File: tb/tb_uart_top.sv
// Randomised self-checking bench for uart_top against a frame-level model.
// Runs at 16 clocks per bit so the whole stream fits in a short simulation.
module tb_uart_top;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_RATE = 3_125_000;
  localparam int CPB      = CLK_HZ / BIT_RATE;

  logic       clk = 1'b0;
  logic [3:0] sw_0;
  logic       uart_rxd;
  logic [3:0] led;

  int         vectors     = 0;
  int         miscompares = 0;
  int         validCount  = 0;
  int         expValid    = 0;
  logic [7:0] expByte     = 8'h00;

  uart_top #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) dut (
    .clk     (clk),
    .sw_0    (sw_0),
    .uart_rxd(uart_rxd),
    .led     (led)
  );

  always #10 clk = ~clk;

  // Counts delivered frames so glitches and disabled frames can be checked.
  always @(negedge clk) begin
    if (dut.u_rx.rx_valid === 1'b1) validCount++;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bitOut(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    bitOut(1'b0);
    for (int i = 0; i < 8; i++) bitOut(data[i]);
    bitOut(stopBit);
    // A low stop bit would look like a new start edge, so let the line idle.
    if (!stopBit) begin
      bitOut(1'b1);
      bitOut(1'b1);
    end
  endtask

  // Frame-level expectation: a frame counts only if reception was enabled at
  // its start edge and, with the frame check built in, its stop bit was high.
  function automatic bit frameDelivered(input bit en, input bit stopBit);
`ifdef UART_RX_FRAME_CHECK_EN
    return en && stopBit;
`else
    return en;
`endif
  endfunction

  task automatic sendAndModel(input logic [7:0] data, input logic stopBit);
    bit en;
    en = sw_0[1];
    applyStimulus(data, stopBit);
    if (frameDelivered(en, stopBit)) begin
      expByte = data;
      expValid++;
    end
  endtask

  task automatic checkAll(input string tag);
    logic keepSel;
    keepSel = sw_0[2];
    sw_0[2] = 1'b0;
    #1;
    checkOutput({tag, "_lo"}, int'(led), int'(expByte[3:0]));
    sw_0[2] = 1'b1;
    #1;
    checkOutput({tag, "_hi"}, int'(led), int'(expByte[7:4]));
    sw_0[2] = keepSel;
    checkOutput({tag, "_nvalid"}, validCount, expValid);
  endtask

  initial begin
    logic [7:0] stream [13];
    logic [7:0] data;
    bit         stopBit;
    bit         en;

    stream = '{8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33, 8'h44, 8'h34,
               8'h00, 8'h61, 8'h62, 8'h63, 8'h64};

    sw_0     = 4'b0010;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_led", int'(led), 0);
    sw_0 = 4'b0011;
    repeat (5) @(negedge clk);
    checkAll("reset");

    sendAndModel(8'h41, 1'b1);
    checkAll("basic_A");
    checkOutput("basic_A_fixed", int'(expByte), 8'h41);

    foreach (stream[i]) begin
      sendAndModel(stream[i], 1'b1);
      checkAll($sformatf("stream%0d", i));
    end
    sw_0[2] = 1'b1;
    #1;
    checkOutput("stream_last_hi", int'(led), 4'b0110);
    sw_0[2] = 1'b0;
    #1;
    checkOutput("stream_last_lo", int'(led), 4'b0100);

    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkAll("glitch");

    sw_0[1] = 1'b0;
    sendAndModel(8'h5A, 1'b1);
    sw_0[1] = 1'b1;
    checkAll("disabled");

    bitOut(1'b0);
    for (int i = 0; i < 4; i++) bitOut(1'b1);
    sw_0[0] = 1'b0;
    expByte = 8'h00;
    #1;
    checkOutput("midreset_led", int'(led), 0);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    sw_0[0] = 1'b1;
    repeat (4) @(negedge clk);
    checkAll("midreset");
    sendAndModel(8'h37, 1'b1);
    checkAll("after_reset");

    sendAndModel(8'h99, 1'b0);
    checkAll("framing");

    for (int n = 0; n < 40; n++) begin
      data    = 8'($urandom);
      en      = ($urandom_range(0, 4) != 0);
      stopBit = ($urandom_range(0, 5) != 0);
      sw_0[1] = en;
      sendAndModel(data, stopBit);
      checkAll($sformatf("rand%0d", n));
    end
    sw_0[1] = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_top.md
# uart_top

Board-level UART receive block: deserialises 8N1 frames on `uart_rxd` and shows a nibble of the last received byte on four green LEDs. It is the top level of the UART demo design. It contains one receiver sub-module plus a display register and LED multiplexer. The slide switches provide reset, receive enable and nibble select.

## Interface
Parameters:
- `BIT_RATE`, default 11520: line rate in bit/s.
- `CLK_HZ`, default 50000000: `clk` frequency in Hz.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `sw_0`, input, 4: slide switches.
  - `sw_0[0]` is `resetn`: one clock, reset asynchronous and active-low.
  - `sw_0[1]` is receive enable (1 = enabled).
  - `sw_0[2]` is nibble select.
  - `sw_0[3]` is reserved and ignored.
- `uart_rxd`, input, 1: asynchronous serial input; idles high.
- `led`, output, 4: display. `led = sw_0[2] ? byte_q[7:4] : byte_q[3:0]`. This mux is combinational; `byte_q` is registered.

## Operation
- `CYCLES_PER_BIT = CLK_HZ / BIT_RATE`, truncated; 4340 for the defaults. `HALF_BIT = CYCLES_PER_BIT / 2`.
  - Width of the bit counter: `$clog2(CYCLES_PER_BIT)`.
  - `CYCLES_PER_BIT < 4` is an elaboration error.
- Synchroniser: a 2-FF chain on `uart_rxd`, reset to 1. The FSM uses only the synchronised value `rxd_s`.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** when `rxd_s == 0` and enable = 1, clear the counter and go to START.
  - **START:** at count `HALF_BIT - 1`, resample. If `rxd_s == 1`, treat it as a glitch and return to IDLE. If 0, clear the counter, set bit index to 0 and go to DATA.
  - **DATA:** at count `CYCLES_PER_BIT - 1`, shift `rxd_s` into the shift register LSB-first and increment the bit index. After bit 7, go to STOP.
  - **STOP:** at count `CYCLES_PER_BIT - 1`, sample the stop bit, pulse `rx_valid` for one cycle and go to IDLE.
- `byte_q` loads the shift-register contents on `rx_valid`; otherwise it holds.
- Enable gates only the IDLE→START transition. A frame already in progress completes even if enable drops.
- Consecutive frames are accepted back-to-back. IDLE is re-entered at mid-stop-bit, so the next start edge is detected.
- Reset values: FSM = IDLE, counter = 0, shift register = 0, `byte_q` = 0x00, `led` = 0000, synchroniser = 1.
- Reset asserted mid-frame aborts the frame immediately. The frame is never delivered.

## Timing
- `led` changes one cycle after `rx_valid`, i.e. when `byte_q` updates, or combinationally when `sw_0[2]` toggles.
- Start edge to `rx_valid` is about `2 + HALF_BIT + 9*CYCLES_PER_BIT` cycles, which is mid-stop-bit.
- `rx_valid` is high for exactly one cycle per accepted frame.
- Tolerated clock/baud mismatch: ±2 % total.

## Configuration
- Macro: `UART_RX_FRAME_CHECK_EN`.
- **Defined:** if the sampled stop bit is 0 (framing error), `rx_valid` is suppressed and `byte_q` is unchanged. The FSM still returns to IDLE.
- **Undefined:** the stop bit is ignored and every frame reaching STOP is delivered.

## Structure
- Package `uart_pkg` contains:
  - the FSM state enum `uart_rx_state_t` (IDLE, START, DATA, STOP);
  - a constant function `cycles_per_bit(clk_hz, bit_rate)`;
  - the constant `UART_DATA_BITS = 8`.
- Sub-module `uart_rx` contains the synchroniser, FSM, counter and shift register.
  - Parameters: `BIT_RATE`, `CLK_HZ`.
  - Outputs: `rx_data[7:0]`, `rx_valid`.
- `uart_top` contains the enable/reset decode, `byte_q` and the LED mux.

## Test plan
All cases use defaults, a 20 ns clock, a 86805 ns bit period and `sw_0 = 4'b0011` unless stated.
- **Basic receive:** send 'A' (0x41) → `led = 0001`; then set `sw_0[2] = 1` → `led = 0100`.
- **Stream:** send 'A','1','B','2','C','3','D','4',0x00,'a','b','c','d' back-to-back.
  - Each `rx_valid` shows the correct byte.
  - After 'd' (0x64), `led = 0100`; with `sw_0[2] = 1`, `led = 0110`.
- **Glitch and enable:**
  - A 1 µs low pulse on `uart_rxd` → no `rx_valid`, `led` unchanged.
  - With `sw_0[1] = 0`, sending 0x5A → `led` unchanged.
- **Reset mid-frame:** send 0xFF and drop `sw_0[0]` after bit 3 → `led = 0000` immediately. Release reset, send 0x37 → `led = 0111`.
- **Framing error:** send 0x99 with the stop bit driven 0.
  - With `UART_RX_FRAME_CHECK_EN` defined → no update.
  - Without it → `led = 1001`.
